contador_acoes_param: RTL
=========================

# contador_acoes_param

Parametrised synchronous action-step counter for the toy-dog controller, replacing the fixed 3-bit ripple counter that cleared itself at state 6. It sequences the dog's action cycle over states 0..LAST with programmable width, up/down direction, wrap or one-shot mode, parallel load, and registered end-of-cycle flags. Everything is fully synchronous to one clock, so no derived clocks or ripple paths exist.

## Interface
- WIDTH, 3, counter width in bits; 1 ≤ WIDTH ≤ 16
- LAST, 5, highest valid state; 1 ≤ LAST ≤ 2^WIDTH − 1
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- restart  in  1  synchronous restart (debounced button, active high)
- en  in  1  step enable; one step per cycle while high
- dir  in  1  1 = count up, 0 = count down
- one_shot  in  1  0 = wrap mode, 1 = stop at terminal state
- load  in  1  synchronous parallel load strobe
- load_val  in  WIDTH  value to load
- count  out  WIDTH  current action state
- last_pulse  out  1  one-cycle flag: a step landed on the terminal state
- wrapped  out  1  one-cycle flag: a wrap occurred this step
- done  out  1  sticky flag: one-shot run finished

## Operation
- The terminal state T depends on dir: T = LAST when dir = 1, T = 0 when dir = 0.
- The block applies at most one action per rising edge, in priority order restart > load > en:
  - restart: count ← 0, done ← 0.
  - load: count ← min(load_val, LAST), done ← 0. Values above LAST are clamped and never cause an illegal state.
  - en, count ≠ T: count ← count + 1 (up) or count − 1 (down). last_pulse ← 1 if the new count equals T.
  - en, count = T, one_shot = 0: count ← 0 (up) or LAST (down). wrapped ← 1. last_pulse ← 1 only if the new value equals T, which is impossible unless LAST = 0 and is excluded.
  - en, count = T, one_shot = 1: count holds and done ← 1.
  - no action: count holds and done holds.
- last_pulse and wrapped are 0 on any cycle that does not satisfy their set condition. They are never asserted on restart or load edges.
- Changing dir or one_shot takes effect on the next step. It never modifies count on its own.
- count never leaves the range 0..LAST by any input sequence.
- Reset (rst_n = 0, asynchronous): count = 0, last_pulse = 0, wrapped = 0, done = 0. The block remains held while rst_n is low. Reset asserted mid-run discards the step in flight.

## Timing
- All outputs are registered. There are no combinational input-to-output paths.
- Step latency is 1 cycle: en sampled high at edge k updates count after edge k.
- last_pulse and wrapped are high for exactly the cycle following the qualifying edge. They are coincident with the new count value.
- done rises on the edge after the blocked step and stays high until restart, load, or reset.
- With en held high in wrap mode, the period is LAST + 1 cycles and wrapped fires once per period.
- Reset release is synchronous to clk from the design's perspective. The first step can occur on the first edge after rst_n goes high with en = 1.

## Test plan
- WIDTH = 3, LAST = 5, en = 1, dir = 1, one_shot = 0, 14 edges after reset -> count sequence 1,2,3,4,5,0,1,2,3,4,5,0,1,2. last_pulse is high on each 5 and wrapped is high on each 0 produced by a wrap.
- Same setup with dir = 0 from count 0 -> 5,4,3,2,1,0,5. wrapped is high on both 5s and last_pulse is high on the 0.
- one_shot = 1, dir = 1, en held high from 0 -> count stops at 5 and done rises one cycle after count reaches 5 and is held. restart then gives count = 0 and done = 0 on the next cycle.
- load = 1 with load_val = 7 (LAST = 5) -> count = 5 with no last_pulse. load and restart asserted together -> count = 0. load and en asserted together with load_val = 2 -> count = 2.
- rst_n pulsed low mid-cycle at count = 3 with en = 1 -> all outputs 0 immediately without a clock edge. After release, counting resumes 1,2,…
- WIDTH = 4, LAST = 9, up wrap -> period of 10 cycles and count is never ≥ 10. WIDTH = 1, LAST = 1 -> 0,1,0,1 with wrapped high on every 0.

Source files
------------

// File: rtl/contador_acoes_param_if.sv
// Control/status bundle for the action-step counter.
// The master side drives the control strobes. The slave side (the counter)
// returns the current state and its registered flags.
interface contador_acoes_param_if #(
    parameter int WIDTH = 3
);
    logic             restart;
    logic             en;
    logic             dir;
    logic             one_shot;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             last_pulse;
    logic             wrapped;
    logic             done;

    modport master (
        output restart, en, dir, one_shot, load, load_val,
        input  count, last_pulse, wrapped, done
    );

    modport slave (
        input  restart, en, dir, one_shot, load, load_val,
        output count, last_pulse, wrapped, done
    );
endinterface

// File: rtl/contador_acoes_param.sv
// Parametrised action-step counter for the toy-dog controller.
// It sequences states 0..LAST with these features:
//   - up/down direction
//   - wrap or one-shot mode
//   - clamped parallel load
//   - registered end-of-cycle flags
// Priority on each edge is restart > load > en. All outputs come straight
// from flops, so there is no combinational path from input to output.
module contador_acoes_param #(
    parameter int WIDTH = 3,
    parameter int LAST  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    contador_acoes_param_if.slave bus
);

    // Highest legal state expressed at counter width.
    localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

    logic [WIDTH-1:0] count_q,      count_d;
    logic             last_pulse_q, last_pulse_d;
    logic             wrapped_q,    wrapped_d;
    logic             done_q,       done_d;

    // Terminal state follows the direction currently requested.
    logic [WIDTH-1:0] term_state;
    // Neighbouring state in the requested direction. It is only used
    // when count is not at the terminal state, so it cannot leave 0..LAST.
    logic [WIDTH-1:0] step_val;
    // Load value limited to the legal range.
    logic [WIDTH-1:0] load_clamped;

    // Derive the terminal state, the next step value and the clamped load value.
    always_comb begin
        term_state   = bus.dir ? LAST_V : '0;
        step_val     = bus.dir ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
        load_clamped = (bus.load_val > LAST_V) ? LAST_V : bus.load_val;
    end

    // Next-state logic: apply at most one action per edge, in priority order.
    always_comb begin
        count_d      = count_q;
        done_d       = done_q;
        last_pulse_d = 1'b0;
        wrapped_d    = 1'b0;

        if (bus.restart) begin
            count_d = '0;
            done_d  = 1'b0;
        end else if (bus.load) begin
            count_d = load_clamped;
            done_d  = 1'b0;
        end else if (bus.en) begin
            if (count_q != term_state) begin
                count_d      = step_val;
                last_pulse_d = (step_val == term_state);
            end else if (!bus.one_shot) begin
                // The wrap lands on the opposite end, which is never the
                // terminal state because LAST >= 1, so last_pulse stays low.
                count_d   = bus.dir ? '0 : LAST_V;
                wrapped_d = 1'b1;
            end else begin
                // One-shot run blocked at the terminal state: hold and latch done.
                done_d = 1'b1;
            end
        end
    end

    // State and flag registers. The asynchronous reset drops any step in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= '0;
            last_pulse_q <= 1'b0;
            wrapped_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            count_q      <= count_d;
            last_pulse_q <= last_pulse_d;
            wrapped_q    <= wrapped_d;
            done_q       <= done_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.last_pulse = last_pulse_q;
    assign bus.wrapped    = wrapped_q;
    assign bus.done       = done_q;

endmodule
